// File: rtl/meu_ram4x16.sv
// 4-entry register bank fed by a 4-way demux, with a registered read port and a clear sequencer.
// Define MEU_RAM4X16_BYPASS_EN so that a same-address read and write returns the new data.
module meu_ram4x16 #(
  parameter int                   LARGURA       = 16,
  parameter logic [LARGURA-1:0]   VALOR_LIMPEZA = {LARGURA{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LARGURA-1:0] canal0,
  input  logic [LARGURA-1:0] canal1,
  input  logic [LARGURA-1:0] canal2,
  input  logic [LARGURA-1:0] canal3,
  input  logic [1:0]         controle_sel,
  input  logic               carga,
  input  logic [1:0]         endereco_leitura,
  input  logic               ler,
  input  logic               limpar,
  output logic [LARGURA-1:0] dado_saida,
  output logic               saida_valida,
  output logic               ocupado,
  output logic [3:0]         preenchido
);

  typedef enum logic [0:0] {OCIOSO = 1'b0, LIMPANDO = 1'b1} estado_t;

  estado_t              estado_q, estado_d;
  logic [1:0]           idx_q, idx_d;
  logic [LARGURA-1:0]   mem_q [4];
  logic [LARGURA-1:0]   dado_saida_q;
  logic                 saida_valida_q;
  logic                 ocupado_q, ocupado_d;
  logic [3:0]           preenchido_q, preenchido_d;

  logic                 wr_en_s;
  logic [1:0]           wr_addr_s;
  logic [LARGURA-1:0]   wr_data_s;
  logic                 rd_en_s;
  logic [LARGURA-1:0]   canal_sel_s;
  logic [LARGURA-1:0]   rd_data_s;

  // State register: FSM state and clear index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      idx_q    <= 2'd0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
    end
  end

  // Next-state logic: clear walks entries 0..3 then returns idle, index wrapping to 0
  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    case (estado_q)
      OCIOSO: begin
        if (limpar) begin
          estado_d = LIMPANDO;
          idx_d    = 2'd0;
        end else begin
          estado_d = OCIOSO;
        end
      end
      LIMPANDO: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          estado_d = OCIOSO;
        end else begin
          estado_d = LIMPANDO;
        end
      end
      default: begin
        estado_d = OCIOSO;
        idx_d    = 2'd0;
      end
    endcase
  end

  // Channel chosen by the same select that steers the upstream demux
  always_comb begin
    canal_sel_s = canal0;
    case (controle_sel)
      2'd0:    canal_sel_s = canal0;
      2'd1:    canal_sel_s = canal1;
      2'd2:    canal_sel_s = canal2;
      2'd3:    canal_sel_s = canal3;
      default: canal_sel_s = canal0;
    endcase
  end

  // Output/control logic: limpar pre-empts carga and ler; everything is dropped while clearing
  always_comb begin
    wr_en_s      = 1'b0;
    wr_addr_s    = controle_sel;
    wr_data_s    = canal_sel_s;
    rd_en_s      = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (limpar) begin
          wr_en_s = 1'b0;
          rd_en_s = 1'b0;
        end else begin
          wr_en_s = carga;
          rd_en_s = ler;
        end
      end
      LIMPANDO: begin
        wr_en_s   = 1'b1;
        wr_addr_s = idx_q;
        wr_data_s = VALOR_LIMPEZA;
      end
      default: begin
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
      end
    endcase

    preenchido_d = preenchido_q;
    if (wr_en_s) begin
      preenchido_d[wr_addr_s] = (estado_q == OCIOSO);
    end else begin
      preenchido_d = preenchido_q;
    end

    ocupado_d = (estado_d == LIMPANDO);

`ifdef MEU_RAM4X16_BYPASS_EN
    if (wr_en_s && (wr_addr_s == endereco_leitura)) begin
      rd_data_s = wr_data_s;
    end else begin
      rd_data_s = mem_q[endereco_leitura];
    end
`else
    rd_data_s = mem_q[endereco_leitura];
`endif
  end

  // Storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= {LARGURA{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_q[wr_addr_s] <= wr_data_s;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dado_saida_q   <= {LARGURA{1'b0}};
      saida_valida_q <= 1'b0;
      ocupado_q      <= 1'b0;
      preenchido_q   <= 4'b0000;
    end else begin
      if (rd_en_s) begin
        dado_saida_q <= rd_data_s;
      end
      saida_valida_q <= rd_en_s;
      ocupado_q      <= ocupado_d;
      preenchido_q   <= preenchido_d;
    end
  end

  assign dado_saida   = dado_saida_q;
  assign saida_valida = saida_valida_q;
  assign ocupado      = ocupado_q;
  assign preenchido   = preenchido_q;

endmodule

// File: tb/tb_meu_ram4x16.sv
// Self-checking bench for meu_ram4x16: directed scenarios plus random traffic against a reference model.
module tb_meu_ram4x16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] c0, c1, c2, c3;
  logic [1:0]  sel, ra;
  logic        carga, ler, limpar;
  logic [15:0] dado_saida;
  logic        saida_valida, ocupado;
  logic [3:0]  preenchido;

  int errors = 0;
  int checks = 0;

  // reference model: contents, fill flags, remaining clear cycles, output regs
  logic [15:0] m_mem [4];
  logic [3:0]  m_pre;
  int          m_left;
  logic [15:0] m_dout;
  logic        m_valid;

  meu_ram4x16 dut (
    .clk(clk), .rst_n(rst_n),
    .canal0(c0), .canal1(c1), .canal2(c2), .canal3(c3),
    .controle_sel(sel), .carga(carga),
    .endereco_leitura(ra), .ler(ler), .limpar(limpar),
    .dado_saida(dado_saida), .saida_valida(saida_valida),
    .ocupado(ocupado), .preenchido(preenchido)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 16'h0000;
    m_pre = 4'b0000; m_left = 0; m_dout = 16'h0000; m_valid = 1'b0;
  endtask

  // One clock edge of the block, computed from the pre-edge inputs
  task automatic model_step();
    logic [15:0] ch [4];
    ch[0] = c0; ch[1] = c1; ch[2] = c2; ch[3] = c3;
    if (m_left > 0) begin
      m_mem[4 - m_left] = 16'h0000;
      m_pre[4 - m_left] = 1'b0;
      m_left--;
      m_valid = 1'b0;
    end else if (limpar) begin
      m_left  = 4;
      m_valid = 1'b0;
    end else begin
      if (ler) begin
`ifdef MEU_RAM4X16_BYPASS_EN
        m_dout = (carga && sel == ra) ? ch[sel] : m_mem[ra];
`else
        m_dout = m_mem[ra];
`endif
      end
      m_valid = ler;
      if (carga) begin
        m_mem[sel] = ch[sel];
        m_pre[sel] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'd0, saida_valida}, {31'd0, m_valid});
    if (m_valid) chk({tag, ".data"}, {16'd0, dado_saida}, {16'd0, m_dout});
    chk({tag, ".busy"}, {31'd0, ocupado}, {31'd0, (m_left > 0)});
    chk({tag, ".fill"}, {28'd0, preenchido}, {28'd0, m_pre});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle_in();
    c0 = 16'h0; c1 = 16'h0; c2 = 16'h0; c3 = 16'h0;
    sel = 2'd0; ra = 2'd0; carga = 1'b0; ler = 1'b0; limpar = 1'b0;
  endtask

  task automatic set_wr(input logic [1:0] s, input logic [15:0] d);
    c0 = 16'h0; c1 = 16'h0; c2 = 16'h0; c3 = 16'h0;
    case (s)
      2'd0: c0 = d;
      2'd1: c1 = d;
      2'd2: c2 = d;
      default: c3 = d;
    endcase
    sel = s; carga = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_rd [4];
    int busy_cnt;
    idle_in();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.dout", {16'd0, dado_saida}, 32'd0);
    rst_n = 1'b1;

    // 1: read a never-written entry
    ra = 2'd2; ler = 1'b1;
    tick("t1.read");
    chk("t1.dout", {16'd0, dado_saida}, 32'h0000);
    idle_in();
    tick("t1.drop");

    // 2: write then read
    set_wr(2'd1, 16'hBEEF);
    tick("t2.wr");
    idle_in(); ra = 2'd1; ler = 1'b1;
    tick("t2.rd");
    chk("t2.dout", {16'd0, dado_saida}, 32'hBEEF);
    chk("t2.fill", {28'd0, preenchido}, 32'h2);

    // 3: fill all, read back 3,0,2,1 on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      set_wr(i[1:0], 16'h1111 * (i + 1));
      tick("t3.wr");
    end
    idle_in(); ler = 1'b1;
    exp_rd[0] = 16'h4444; exp_rd[1] = 16'h1111; exp_rd[2] = 16'h3333; exp_rd[3] = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      ra = (i == 0) ? 2'd3 : (i == 1) ? 2'd0 : (i == 2) ? 2'd2 : 2'd1;
      tick("t3.rd");
      chk("t3.seq", {16'd0, dado_saida}, {16'd0, exp_rd[i]});
    end
    idle_in();
    tick("t3.idle");

    // 4: clear with a simultaneous write; reads during busy are dropped
    set_wr(2'd2, 16'hDEAD); limpar = 1'b1;
    tick("t4.start");
    idle_in(); ler = 1'b1; ra = 2'd0;
    busy_cnt = (ocupado === 1'b1) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      tick("t4.busy");
      if (ocupado === 1'b1) busy_cnt++;
      if (i < 3) chk("t4.novalid", {31'd0, saida_valida}, 32'd0);
    end
    chk("t4.busycnt", busy_cnt, 32'd4);
    for (int i = 0; i < 4; i++) begin
      ra = i[1:0];
      tick("t4.rd");
      chk("t4.zero", {16'd0, dado_saida}, 32'h0);
    end
    chk("t4.fill", {28'd0, preenchido}, 32'h0);

    // 5: same-address read/write collision
    idle_in(); set_wr(2'd0, 16'hAAAA);
    tick("t5.pre");
    set_wr(2'd0, 16'h5555); ra = 2'd0; ler = 1'b1;
    tick("t5.col");
`ifdef MEU_RAM4X16_BYPASS_EN
    chk("t5.col.dout", {16'd0, dado_saida}, 32'h5555);
`else
    chk("t5.col.dout", {16'd0, dado_saida}, 32'hAAAA);
`endif
    idle_in(); ra = 2'd0; ler = 1'b1;
    tick("t5.after");
    chk("t5.after.dout", {16'd0, dado_saida}, 32'h5555);

    // 6: reset in the middle of a clear
    idle_in(); limpar = 1'b1;
    tick("t6.start");
    idle_in();
    tick("t6.c1");
    tick("t6.c2");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("t6.rst");
    chk("t6.rst.dout", {16'd0, dado_saida}, 32'h0);
    #2;
    rst_n = 1'b1;
    set_wr(2'd3, 16'h0F0F); ra = 2'd1; ler = 1'b1;
    tick("t6.first");
    idle_in(); ra = 2'd3; ler = 1'b1;
    tick("t6.rd");
    chk("t6.rd.dout", {16'd0, dado_saida}, 32'h0F0F);

    // random traffic; non-selected channels carry junk that must be ignored
    for (int n = 0; n < 400; n++) begin
      c0 = 16'($urandom); c1 = 16'($urandom); c2 = 16'($urandom); c3 = 16'($urandom);
      sel = 2'($urandom_range(0, 3)); ra = 2'($urandom_range(0, 3));
      carga = 1'($urandom_range(0, 1)); ler = 1'($urandom_range(0, 1));
      limpar = ($urandom_range(0, 15) == 0);
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
